mem_port_arbiter: RTL and testbench

- Arbitrates one shared memory port between two requesters: instruction fetch (requester 0) and the execution-stage load/store unit (requester 1).
- Sits between the fetch unit, the execution load/store path and the memory model.
- Serialises one transaction at a time, returns read data and a completion pulse to the owner, and reports an error on a hung memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   state_t       - arbiter FSM encoding (IDLE / WAIT)
//   REQ_IF/REQ_EX - requester index (owner / last_owner encoding)
//   MAX_WAIT_DEF  - default mem_ack timeout in cycles
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic REQ_IF = 1'b0;   // instruction fetch
   localparam logic REQ_EX = 1'b1;   // execution load/store unit

   localparam int MAX_WAIT_DEF = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch, load/store and memory handshakes of the arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives grants,
//            completions and the memory request)
//   master : environment view (fetch unit, load/store unit and memory model)
// Parameters: ADDR_W address width, DATA_W data width.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   // fetch requester
   logic              if_req_valid;
   logic [ADDR_W-1:0] if_addr;
   logic              if_grant;
   logic              if_data_valid;
   logic [DATA_W-1:0] if_rdata;

   // load/store requester
   logic              ex_req_valid;
   logic [ADDR_W-1:0] ex_addr;
   logic              ex_we;
   logic [DATA_W-1:0] ex_wdata;
   logic              ex_grant;
   logic              ex_data_valid;
   logic [DATA_W-1:0] ex_rdata;

   // shared memory port
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req_valid, if_addr,
      input  ex_req_valid, ex_addr, ex_we, ex_wdata,
      input  mem_ack, mem_rdata,
      output if_grant, if_data_valid, if_rdata,
      output ex_grant, ex_data_valid, ex_rdata,
      output mem_req, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output if_req_valid, if_addr,
      output ex_req_valid, ex_addr, ex_we, ex_wdata,
      output mem_ack, mem_rdata,
      input  if_grant, if_data_valid, if_rdata,
      input  ex_grant, ex_data_valid, ex_rdata,
      input  mem_req, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select for the two requesters.
// Ports:
//   if_req, ex_req : request valids of fetch / load-store
//   last_owner     : requester granted most recently (REQ_IF / REQ_EX)
//   req_any        : at least one request pending
//   winner         : selected requester (REQ_IF / REQ_EX), meaningful when req_any
// Build option MEM_ARB_RR_EN: round-robin on contention (the requester not
// granted last wins). Without it, load/store always beats fetch.
// -----------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic ex_req,
   input  logic last_owner,
   output logic req_any,
   output logic winner
);

   always_comb begin
      req_any = if_req | ex_req;
      winner  = REQ_IF;
`ifdef MEM_ARB_RR_EN
      if (if_req && ex_req) begin
         winner = ~last_owner;
      end else if (ex_req) begin
         winner = REQ_EX;
      end
`else
      if (ex_req) begin
         winner = REQ_EX;
      end
`endif
   end

`ifndef MEM_ARB_RR_EN
   // Fixed priority ignores history; the port stays so both builds share one
   // instantiation.
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch and the load/store unit.
// One transaction at a time: IDLE picks a winner and latches its request onto
// the mem_* registers, WAIT holds mem_req until mem_ack (or a timeout abort),
// then returns data and a completion pulse to the owner.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (fetch / load-store / memory)
//   busy       : transaction in flight
//   arb_err    : one-cycle pulse when a transaction is aborted on timeout
// Parameters: ADDR_W, DATA_W, MAX_WAIT (mem_ack timeout in cycles).
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   mem_port_arbiter_if.slave        bus,
   output logic                     busy,
   output logic                     arb_err
);

   localparam int                CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic               owner;
   logic               last_owner;

   logic               if_grant_q;
   logic               if_dv_q;
   logic [DATA_W-1:0]  if_rdata_q;
   logic               ex_grant_q;
   logic               ex_dv_q;
   logic [DATA_W-1:0]  ex_rdata_q;
   logic               mem_req_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic               mem_we_q;
   logic [DATA_W-1:0]  mem_wdata_q;

   logic               req_any;
   logic               winner;

   mem_arb_pick u_pick (
      .if_req     (bus.if_req_valid),
      .ex_req     (bus.ex_req_valid),
      .last_owner (last_owner),
      .req_any    (req_any),
      .winner     (winner)
   );

   always_ff @(posedge clk) begin
      // NOTE: every register here, data included, is cleared by reset so that
      // all outputs read 0 after reset and a dropped transaction leaves nothing
      // behind; all state uses non-blocking assignments so the FSM sees
      // pre-edge values throughout.
      if (reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         owner       <= REQ_IF;
         last_owner  <= REQ_IF;
         if_grant_q  <= 1'b0;
         if_dv_q     <= 1'b0;
         if_rdata_q  <= '0;
         ex_grant_q  <= 1'b0;
         ex_dv_q     <= 1'b0;
         ex_rdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         busy        <= 1'b0;
         arb_err     <= 1'b0;
      end else begin
         // pulses default low every cycle
         if_grant_q <= 1'b0;
         ex_grant_q <= 1'b0;
         if_dv_q    <= 1'b0;
         ex_dv_q    <= 1'b0;
         arb_err    <= 1'b0;

         case (state)
            ST_IDLE: begin
               // mem_ack is ignored here: nothing is outstanding
               if (req_any) begin
                  owner      <= winner;
                  last_owner <= winner;
                  mem_req_q  <= 1'b1;
                  busy       <= 1'b1;
                  wait_cnt   <= '0;
                  state      <= ST_WAIT;
                  if (winner == REQ_EX) begin
                     ex_grant_q  <= 1'b1;
                     mem_addr_q  <= bus.ex_addr;
                     mem_we_q    <= bus.ex_we;
                     mem_wdata_q <= bus.ex_wdata;
                  end else begin
                     // fetch is always a read
                     if_grant_q  <= 1'b1;
                     mem_addr_q  <= bus.if_addr;
                     mem_we_q    <= 1'b0;
                     mem_wdata_q <= '0;
                  end
               end
            end

            ST_WAIT: begin
               if (bus.mem_ack) begin
                  // ack beats a timeout landing in the same cycle
                  mem_req_q <= 1'b0;
                  busy      <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ST_IDLE;
                  if (owner == REQ_EX) begin
                     ex_dv_q <= 1'b1;
                     if (!mem_we_q) begin
                        ex_rdata_q <= bus.mem_rdata;
                     end
                  end else begin
                     if_dv_q    <= 1'b1;
                     if_rdata_q <= bus.mem_rdata;
                  end
               end else if (wait_cnt == CNT_MAX) begin
                  // hung memory: complete the owner with zero data and flag it
                  mem_req_q <= 1'b0;
                  busy      <= 1'b0;
                  arb_err   <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= ST_IDLE;
                  if (owner == REQ_EX) begin
                     ex_dv_q    <= 1'b1;
                     ex_rdata_q <= '0;
                  end else begin
                     if_dv_q    <= 1'b1;
                     if_rdata_q <= '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.if_grant      = if_grant_q;
   assign bus.if_data_valid = if_dv_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.ex_grant      = ex_grant_q;
   assign bus.ex_data_valid = ex_dv_q;
   assign bus.ex_rdata      = ex_rdata_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with MAX_WAIT = 4. Inputs change and
// outputs are sampled 1 time unit after each rising edge. Expected arbitration
// order follows MEM_ARB_RR_EN when that macro is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int TB_MAX_WAIT = 4;

   logic clk;
   logic reset;
   logic busy;
   logic arb_err;

   int n_tests;
   int n_fail;

   // model of ex_rdata as last delivered by this bench
   logic [DATA_W-1:0] exp_ex_rdata;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (TB_MAX_WAIT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy),
      .arb_err (arb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [135:0] all_outputs();
      return {bus.if_grant, bus.if_data_valid, bus.if_rdata,
              bus.ex_grant, bus.ex_data_valid, bus.ex_rdata,
              bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata,
              busy, arb_err};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_tests++;
      if (all_outputs() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", all_outputs());
      end
      reset = 1'b0;
      step();
      n_tests++;
      if ({busy, bus.mem_req, bus.if_grant, bus.ex_grant} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy/mem_req/grants %b want 0000",
                  {busy, bus.mem_req, bus.if_grant, bus.ex_grant});
      end
   endtask

   task automatic test_fetch_read();
      logic bad;
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h0000_0100;
      step();
      n_tests++;
      if ({bus.if_grant, bus.ex_grant, bus.mem_req, bus.mem_we, busy} !== 5'b10101 ||
          bus.mem_addr !== 32'h0000_0100 || bus.mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL fetch_grant: grant/exg/req/we/busy=%b addr=%h wdata=%h want 10101 00000100 0",
                  {bus.if_grant, bus.ex_grant, bus.mem_req, bus.mem_we, busy},
                  bus.mem_addr, bus.mem_wdata);
      end
      bus.if_req_valid = 1'b0;
      bus.if_addr      = '0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (!busy || !bus.mem_req || bus.if_grant || bus.if_data_valid ||
             bus.mem_addr !== 32'h0000_0100)
            bad = 1'b1;
      end
      n_tests++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_wait_hold: got bad=%b want 0", bad);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      n_tests++;
      if ({bus.if_data_valid, bus.ex_data_valid, bus.mem_req, busy, arb_err} !== 5'b10000 ||
          bus.if_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL fetch_done: dv/exdv/req/busy/err=%b rdata=%h want 10000 deadbeef",
                  {bus.if_data_valid, bus.ex_data_valid, bus.mem_req, busy, arb_err},
                  bus.if_rdata);
      end
      step();
      n_tests++;
      if (bus.if_data_valid !== 1'b0 || bus.if_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL fetch_dv_pulse: dv=%b rdata=%h want 0 deadbeef",
                  bus.if_data_valid, bus.if_rdata);
      end
   endtask

   task automatic test_contention();
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h0000_0104;
      bus.ex_req_valid = 1'b1;
      bus.ex_addr      = 32'h0000_0400;
      bus.ex_we        = 1'b0;
      step();
      n_tests++;
      if ({bus.ex_grant, bus.if_grant} !== 2'b10 || bus.mem_addr !== 32'h0000_0400) begin
         n_fail++;
         $display("FAIL contention_first: exg/ifg=%b addr=%h want 10 00000400",
                  {bus.ex_grant, bus.if_grant}, bus.mem_addr);
      end
      bus.ex_req_valid = 1'b0;
      step();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hA5A5_0001;
      step();
      bus.mem_ack   = 1'b0;
      exp_ex_rdata  = 32'hA5A5_0001;
      n_tests++;
      if ({bus.ex_data_valid, bus.if_data_valid, bus.if_grant} !== 3'b100 ||
          bus.ex_rdata !== exp_ex_rdata) begin
         n_fail++;
         $display("FAIL contention_ex_done: exdv/ifdv/ifg=%b rdata=%h want 100 %h",
                  {bus.ex_data_valid, bus.if_data_valid, bus.if_grant}, bus.ex_rdata, exp_ex_rdata);
      end
      step();
      n_tests++;
      if ({bus.if_grant, bus.ex_grant} !== 2'b10 || bus.mem_addr !== 32'h0000_0104) begin
         n_fail++;
         $display("FAIL contention_second: ifg/exg=%b addr=%h want 10 00000104",
                  {bus.if_grant, bus.ex_grant}, bus.mem_addr);
      end
      bus.if_req_valid = 1'b0;
      step();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1111_0002;
      step();
      bus.mem_ack   = 1'b0;
      n_tests++;
      if (bus.if_data_valid !== 1'b1 || bus.if_rdata !== 32'h1111_0002) begin
         n_fail++;
         $display("FAIL contention_if_done: dv=%b rdata=%h want 1 11110002",
                  bus.if_data_valid, bus.if_rdata);
      end
   endtask

   task automatic test_repeated_contention();
      logic [3:0] seq;
      logic [3:0] exp_seq;
      logic       got;
      int         n;
      logic [DATA_W-1:0] rd;
`ifdef MEM_ARB_RR_EN
      exp_seq = 4'b0101;   // ex, if, ex, if (bit 0 first, 1 = ex)
`else
      exp_seq = 4'b1111;   // ex every time
`endif
      seq = '0;
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h0000_0108;
      bus.ex_req_valid = 1'b1;
      bus.ex_addr      = 32'h0000_0500;
      bus.ex_we        = 1'b0;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         n   = 0;
         while (!got && n < 20) begin
            step();
            n++;
            if (bus.if_grant || bus.ex_grant) got = 1'b1;
         end
         n_tests++;
         if (got !== 1'b1 || (bus.if_grant && bus.ex_grant)) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got grant=%b ifg/exg=%b want exactly one grant",
                     g, got, {bus.if_grant, bus.ex_grant});
            break;
         end
         seq[g] = bus.ex_grant;
         if (bus.ex_grant) bus.ex_req_valid = 1'b0;
         else              bus.if_req_valid = 1'b0;
         rd = 32'h5000_0000 + DATA_W'(g);
         step();
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = rd;
         step();
         bus.mem_ack   = 1'b0;
         n_tests++;
         if (seq[g]) begin
            exp_ex_rdata = rd;
            if ({bus.ex_data_valid, bus.if_data_valid} !== 2'b10 || bus.ex_rdata !== rd) begin
               n_fail++;
               $display("FAIL rr_done_%0d: exdv/ifdv=%b rdata=%h want 10 %h",
                        g, {bus.ex_data_valid, bus.if_data_valid}, bus.ex_rdata, rd);
            end
            bus.ex_req_valid = (g < 3);
         end else begin
            if ({bus.ex_data_valid, bus.if_data_valid} !== 2'b01 || bus.if_rdata !== rd) begin
               n_fail++;
               $display("FAIL rr_done_%0d: exdv/ifdv=%b rdata=%h want 01 %h",
                        g, {bus.ex_data_valid, bus.if_data_valid}, bus.if_rdata, rd);
            end
            bus.if_req_valid = (g < 3);
         end
         if (g == 3) begin
            bus.if_req_valid = 1'b0;
            bus.ex_req_valid = 1'b0;
         end
      end
      n_tests++;
      if (seq !== exp_seq) begin
         n_fail++;
         $display("FAIL rr_sequence: got %b want %b", seq, exp_seq);
      end
      step();
   endtask

   task automatic test_store();
      bus.ex_req_valid = 1'b1;
      bus.ex_we        = 1'b1;
      bus.ex_addr      = 32'h0000_2000;
      bus.ex_wdata     = 32'h1234_5678;
      step();
      n_tests++;
      if ({bus.ex_grant, bus.mem_req, bus.mem_we} !== 3'b111 ||
          bus.mem_addr !== 32'h0000_2000 || bus.mem_wdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL store_grant: exg/req/we=%b addr=%h wdata=%h want 111 00002000 12345678",
                  {bus.ex_grant, bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
      end
      bus.ex_req_valid = 1'b0;
      bus.ex_we        = 1'b0;
      bus.ex_addr      = '0;
      bus.ex_wdata     = '0;
      step();
      n_tests++;
      if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_addr !== 32'h0000_2000) begin
         n_fail++;
         $display("FAIL store_hold: we=%b addr=%h wdata=%h want 1 00002000 12345678",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_BAD0;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      n_tests++;
      if ({bus.ex_data_valid, bus.mem_req, arb_err} !== 3'b100 || bus.ex_rdata !== exp_ex_rdata) begin
         n_fail++;
         $display("FAIL store_done: exdv/req/err=%b rdata=%h want 100 %h",
                  {bus.ex_data_valid, bus.mem_req, arb_err}, bus.ex_rdata, exp_ex_rdata);
      end
      step();
   endtask

   task automatic test_timeout();
      int  n;
      logic seen;
      logic early;
      bus.ex_req_valid = 1'b1;
      bus.ex_we        = 1'b0;
      bus.ex_addr      = 32'h0000_0300;
      step();
      bus.ex_req_valid = 1'b0;
      n     = 0;
      seen  = 1'b0;
      early = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (arb_err) seen = 1'b1;
         else if (bus.ex_data_valid || !bus.mem_req) early = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b1 || early !== 1'b0 || n != TB_MAX_WAIT + 1) begin
         n_fail++;
         $display("FAIL timeout_arrival: seen=%b early=%b cycles=%0d want 1 0 %0d",
                  seen, early, n, TB_MAX_WAIT + 1);
      end
      exp_ex_rdata = '0;
      n_tests++;
      if ({bus.ex_data_valid, bus.if_data_valid, bus.mem_req, busy} !== 4'b1000 ||
          bus.ex_rdata !== '0) begin
         n_fail++;
         $display("FAIL timeout_abort: exdv/ifdv/req/busy=%b rdata=%h want 1000 0",
                  {bus.ex_data_valid, bus.if_data_valid, bus.mem_req, busy}, bus.ex_rdata);
      end
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h0000_010C;
      step();
      n_tests++;
      if ({bus.if_grant, arb_err, bus.mem_req} !== 3'b101 || bus.mem_addr !== 32'h0000_010C) begin
         n_fail++;
         $display("FAIL timeout_recover: ifg/err/req=%b addr=%h want 101 0000010c",
                  {bus.if_grant, arb_err, bus.mem_req}, bus.mem_addr);
      end
      bus.if_req_valid = 1'b0;
      bus.mem_ack      = 1'b1;
      bus.mem_rdata    = 32'h0C0C_0C0C;
      step();
      bus.mem_ack      = 1'b0;
      n_tests++;
      if (bus.if_data_valid !== 1'b1 || bus.if_rdata !== 32'h0C0C_0C0C || arb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_recover_done: dv=%b rdata=%h err=%b want 1 0c0c0c0c 0",
                  bus.if_data_valid, bus.if_rdata, arb_err);
      end
      step();
   endtask

   task automatic test_ack_at_limit();
      logic bad;
      bus.ex_req_valid = 1'b1;
      bus.ex_addr      = 32'h0000_0600;
      bus.ex_we        = 1'b0;
      step();
      bus.ex_req_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < TB_MAX_WAIT; i++) begin
         step();
         if (arb_err || bus.ex_data_valid || !bus.mem_req) bad = 1'b1;
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h7777_8888;
      step();
      bus.mem_ack   = 1'b0;
      exp_ex_rdata  = 32'h7777_8888;
      n_tests++;
      if (bad !== 1'b0 || {bus.ex_data_valid, arb_err, bus.mem_req} !== 3'b100 ||
          bus.ex_rdata !== exp_ex_rdata) begin
         n_fail++;
         $display("FAIL ack_at_limit: early=%b exdv/err/req=%b rdata=%h want 0 100 %h",
                  bad, {bus.ex_data_valid, arb_err, bus.mem_req}, bus.ex_rdata, exp_ex_rdata);
      end
      step();
   endtask

   task automatic test_reset_mid_wait();
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h0000_0110;
      step();
      bus.if_req_valid = 1'b0;
      step();
      step();
      n_tests++;
      if ({busy, bus.mem_req} !== 2'b11) begin
         n_fail++;
         $display("FAIL midwait_setup: busy/req=%b want 11", {busy, bus.mem_req});
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_tests++;
      if (all_outputs() !== '0) begin
         n_fail++;
         $display("FAIL midwait_reset: got %h want 0", all_outputs());
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      n_tests++;
      if (all_outputs() !== '0) begin
         n_fail++;
         $display("FAIL stale_ack: got %h want 0", all_outputs());
      end
      step();
      n_tests++;
      if (all_outputs() !== '0) begin
         n_fail++;
         $display("FAIL stale_ack_after: got %h want 0", all_outputs());
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      exp_ex_rdata     = '0;
      reset            = 1'b1;
      bus.if_req_valid = 1'b0;
      bus.if_addr      = '0;
      bus.ex_req_valid = 1'b0;
      bus.ex_addr      = '0;
      bus.ex_we        = 1'b0;
      bus.ex_wdata     = '0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = '0;

      test_reset();
      test_fetch_read();
      test_contention();
      test_repeated_contention();
      test_store();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_wait();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
